// File: rtl/display_buffer_loader.sv
// -----------------------------------------------------------------------------
// display_buffer_loader
//
// Avalon-MM slave that bulk-loads pixels into the LED tile display buffer.
// Software preloads 24-bit RGB pixels into an internal FIFO, sets BASE and
// COUNT, then issues START. The block streams the pixels to consecutive
// buffer addresses over a write/ready handshake. On completion it sets a
// sticky done flag, which can raise a level interrupt.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave write/read access
//   write_n, writedata,
//   readdata              combinational read data (zero-extended)
//   buf_addr, buf_data,   display buffer write request; buf_ready accepts it
//   buf_we, buf_ready
//   irq                   done & irq_en
//
// Optional feature: define DISPLAY_BUFFER_LOADER_CHECKSUM_EN to add a 24-bit
// running sum of accepted pixels at address 5 (any write clears it, START
// clears it). Without the macro, address 5 reads 0.
// -----------------------------------------------------------------------------
module display_buffer_loader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [23:0]       buf_data,
    output logic              buf_we,
    input  logic              buf_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0]    count_q, remaining_q, remaining_d;
    logic                irq_en_q;
    logic                done_q, done_d, done_set;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [23:0]         fifo_mem [FIFO_DEPTH];

    logic bus_wr, wr_ctrl, wr_base, wr_count, wr_pixel, wr_status;
    logic start, abort, start_accept;
    logic fifo_empty, fifo_full, push_ok, pop;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:24];

    // Register decode
    assign bus_wr    = chipselect && !write_n;
    assign wr_ctrl   = bus_wr && (address == 3'd0);
    assign wr_base   = bus_wr && (address == 3'd1);
    assign wr_count  = bus_wr && (address == 3'd2);
    assign wr_pixel  = bus_wr && (address == 3'd3);
    assign wr_status = bus_wr && (address == 3'd4);

    // ABORT dominates a simultaneous START
    assign abort        = wr_ctrl && writedata[1];
    assign start        = wr_ctrl && writedata[0] && !writedata[1];
    assign start_accept = start && (state_q == S_IDLE);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign push_ok    = wr_pixel && !fifo_full;

    // Write request and handshake
    assign buf_we   = (state_q == S_XFER) && !fifo_empty;
    assign pop      = buf_we && buf_ready;
    assign buf_addr = addr_cnt_q;
    // Gate the head so the port is zero whenever no write is requested
    // (the storage itself is never reset).
    assign buf_data = buf_we ? fifo_mem[rd_ptr_q] : 24'd0;
    assign irq      = done_q && irq_en_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        remaining_d = remaining_q;
        done_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_q != '0) begin
                        state_d     = S_XFER;
                        addr_cnt_d  = base_q;
                        remaining_d = count_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_XFER: begin
                if (pop) begin
                    addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            done_set = 1'b0;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C wins
    assign done_d = done_set || (done_q && !(wr_status && writedata[0]));
    assign ovf_d  = (wr_pixel && fifo_full) || (ovf_q && !(wr_status && writedata[1]));

    // FIFO pointers and level; abort flushes everything including a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= writedata[23:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            addr_cnt_q  <= addr_cnt_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            if (wr_ctrl)  irq_en_q <= writedata[2];
            if (wr_base)  base_q   <= writedata[ADDR_W-1:0];
            if (wr_count) count_q  <= writedata[CNT_W-1:0];
        end
    end

`ifdef DISPLAY_BUFFER_LOADER_CHECKSUM_EN
    logic [23:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (pop) csum_d = csum_q + buf_data;
        if (start_accept || (bus_wr && (address == 3'd5))) csum_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

    // Read mux
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = {29'd0, irq_en_q, done_q, (state_q != S_IDLE)};
            3'd1: readdata = {{(32-ADDR_W){1'b0}}, base_q};
            3'd2: readdata = {{(32-CNT_W){1'b0}}, count_q};
            3'd3: readdata = {{(32-LVL_W){1'b0}}, level_q};
            3'd4: readdata = {30'd0, ovf_q, done_q};
`ifdef DISPLAY_BUFFER_LOADER_CHECKSUM_EN
            3'd5: readdata = {8'd0, csum_q};
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_display_buffer_loader.sv
module tb_display_buffer_loader;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  buf_addr;
    logic [23:0] buf_data;
    logic        buf_we;
    logic        buf_ready;
    logic        irq;

    display_buffer_loader #(.ADDR_W(10), .FIFO_DEPTH(16), .CNT_W(11)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_we     (buf_we),
        .buf_ready  (buf_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [23:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks  = 0;
    int  errors  = 0;
    int  acc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: the write is sampled on the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("bus write addr=%0d data=0x%0h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        $display("bus read  addr=%0d data=0x%0h", a, d);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pixel(input logic [9:0] a, input logic [23:0] d, input bit expect_wr);
        if (expect_wr) exp_q.push_back('{addr: a, data: d});
        bus_write(3'd3, {8'd0, d});
    endtask

    // Scoreboard: accepted writes must match the queue head; stalled requests
    // must present the head unchanged.
    always @(negedge clk) begin
        if (reset_n && buf_we) begin
            if (buf_ready) begin
                acc_cnt++;
                $display("buffer write addr=0x%0h data=0x%0h", buf_addr, buf_data);
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_write observed=0x%0h/0x%0h expected=none", buf_addr, buf_data);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", {22'd0, buf_addr}, {22'd0, mon_e.addr});
                    check("wr_data", {8'd0, buf_data}, {8'd0, mon_e.data});
                end
            end else if (exp_q.size() != 0) begin
                check("hold_addr", {22'd0, buf_addr}, {22'd0, exp_q[0].addr});
                check("hold_data", {8'd0, buf_data}, {8'd0, exp_q[0].data});
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int          acc0;

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        buf_ready  = 1'b0;
        cycles(2);

        // Reset state
        check("rst_we",   {31'd0, buf_we}, 32'd0);
        check("rst_addr", {22'd0, buf_addr}, 32'd0);
        check("rst_data", {8'd0, buf_data}, 32'd0);
        check("rst_irq",  {31'd0, irq}, 32'd0);
        bus_read(3'd0, rd); check("rst_ctrl", rd, 32'd0);
        bus_read(3'd3, rd); check("rst_level", rd, 32'd0);
        reset_n = 1'b1;
        cycles(1);

        // 1: wrap-around burst at full throughput
        for (int i = 0; i < 4; i++) push_pixel(10'((10'h3FE + i) & 10'h3FF), 24'(i + 1), 1'b1);
        bus_write(3'd1, 32'h3FE);
        bus_write(3'd2, 32'd4);
        buf_ready = 1'b1;
        acc0 = acc_cnt;
        bus_write(3'd0, 32'h1);
        check("t1_we_latency", {31'd0, buf_we}, 32'd1);
        cycles(4);
        check("t1_accepted", acc_cnt - acc0, 32'd4);
        check("t1_queue_empty", exp_q.size(), 32'd0);
        bus_read(3'd0, rd); check("t1_ctrl_in_done", rd, 32'b001);
        cycles(1);
        bus_read(3'd0, rd); check("t1_ctrl_after", rd, 32'b010);
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, rd); check("t1_status_clr", rd, 32'd0);

        // 2: back-pressure on the second pixel
        for (int i = 0; i < 3; i++) push_pixel(10'(10'h100 + i), 24'(24'hA0 + i), 1'b1);
        bus_write(3'd1, 32'h100);
        bus_write(3'd2, 32'd3);
        acc0 = acc_cnt;
        bus_write(3'd0, 32'h1);
        cycles(1);
        buf_ready = 1'b0;
        cycles(5);
        check("t2_stall_addr", {22'd0, buf_addr}, 32'h101);
        check("t2_stall_data", {8'd0, buf_data}, 32'hA1);
        buf_ready = 1'b1;
        cycles(3);
        check("t2_accepted", acc_cnt - acc0, 32'd3);
        check("t2_queue_empty", exp_q.size(), 32'd0);
        bus_read(3'd4, rd); check("t2_status_done", rd, 32'h1);
        bus_write(3'd4, 32'h1);

        // 3: overflow
        buf_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_pixel(10'd0, 24'(24'h500 + i), 1'b0);
        bus_read(3'd3, rd); check("t3_level_full", rd, 32'd16);
        bus_read(3'd4, rd); check("t3_overflow", rd, 32'h2);
        bus_write(3'd4, 32'h2);
        bus_read(3'd4, rd); check("t3_ovf_clr", rd, 32'd0);
        bus_write(3'd0, 32'h2);
        bus_read(3'd3, rd); check("t3_flushed", rd, 32'd0);

        // 4: COUNT=0 goes straight to DONE with no write
        buf_ready = 1'b1;
        bus_write(3'd2, 32'd0);
        acc0 = acc_cnt;
        bus_write(3'd0, 32'h5);
        check("t4_no_we", {31'd0, buf_we}, 32'd0);
        cycles(1);
        check("t4_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd0, rd); check("t4_ctrl", rd, 32'b110);
        check("t4_no_write", acc_cnt - acc0, 32'd0);
        bus_write(3'd4, 32'h1);
        check("t4_irq_clr", {31'd0, irq}, 32'd0);

        // 5: ABORT mid-transfer
        bus_write(3'd1, 32'h20);
        bus_write(3'd2, 32'd8);
        push_pixel(10'h20, 24'hB0, 1'b1);
        push_pixel(10'h21, 24'hB1, 1'b1);
        acc0 = acc_cnt;
        bus_write(3'd0, 32'h5);
        cycles(2);
        check("t5_accepted", acc_cnt - acc0, 32'd2);
        bus_read(3'd0, rd); check("t5_busy", rd, 32'b101);
        buf_ready = 1'b0;
        push_pixel(10'h22, 24'hB2, 1'b1);
        check("t5_we_pending", {31'd0, buf_we}, 32'd1);
        bus_write(3'd0, 32'h6);
        check("t5_we_drop", {31'd0, buf_we}, 32'd0);
        bus_read(3'd0, rd); check("t5_ctrl", rd, 32'b100);
        bus_read(3'd3, rd); check("t5_level", rd, 32'd0);
        check("t5_irq", {31'd0, irq}, 32'd0);
        exp_q.delete();

        // 6: reset mid-transfer
        bus_write(3'd1, 32'h30);
        bus_write(3'd2, 32'd4);
        push_pixel(10'h30, 24'hC0, 1'b1);
        bus_write(3'd0, 32'h1);
        check("t6_we", {31'd0, buf_we}, 32'd1);
        check("t6_addr", {22'd0, buf_addr}, 32'h30);
        reset_n = 1'b0;
        #1;
        check("t6_rst_we", {31'd0, buf_we}, 32'd0);
        check("t6_rst_addr", {22'd0, buf_addr}, 32'd0);
        check("t6_rst_data", {8'd0, buf_data}, 32'd0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        cycles(1);
        reset_n = 1'b1;
        exp_q.delete();
        cycles(1);
        bus_read(3'd0, rd); check("t6_ctrl", rd, 32'd0);
        bus_read(3'd1, rd); check("t6_base", rd, 32'd0);

        // 7: checksum register (reads 0 when the feature is absent)
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'd2);
        push_pixel(10'h0, 24'hFFFFFF, 1'b1);
        push_pixel(10'h1, 24'h000002, 1'b1);
        buf_ready = 1'b1;
        acc0 = acc_cnt;
        bus_write(3'd0, 32'h1);
        cycles(3);
        check("t7_accepted", acc_cnt - acc0, 32'd2);
        bus_read(3'd5, rd);
`ifdef DISPLAY_BUFFER_LOADER_CHECKSUM_EN
        check("t7_checksum", rd, 32'h000001);
`else
        check("t7_addr5", rd, 32'd0);
`endif
        bus_read(3'd6, rd); check("t7_addr6", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
